dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter: MAX_HOLD, default 4, max consecutive transfers by one owner while the other master waits (range 1..15).
REQ-002 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports, per master x in {0,1}: req_x  input  1  request, held high with stable payload until granted.
REQ-005 SHALL have ports: addr_x  input  32, wdata_x  input  32, byteen_x  input  4  (byteen_x==0 means read).
REQ-006 SHALL have ports: gnt_x  output  1  registered grant; rvalid_x  output  1  read data valid this cycle.
REQ-007 SHALL have ports: rdata  output  32  shared read data, equals bus_rdata.
REQ-008 SHALL have ports: bus_addr  output  32, bus_wdata  output  32, bus_byteen  output  4  to memory bridge.
REQ-009 SHALL have port: bus_rdata  input  32  same-cycle read data from memory bridge.

Function
REQ-010 SHALL keep owner state in {NONE, M0, M1}, and a last-served flag.
REQ-011 SHALL drive gnt_0 = (owner==M0), gnt_1 = (owner==M1), directly from registers.
REQ-012 SHALL count a transfer in every cycle where gnt_x & req_x; one transfer per cycle.
REQ-013 SHALL drive bus_addr/bus_wdata/bus_byteen from the owner's inputs when owner's req is high; otherwise all zero.
REQ-014 SHALL assert rvalid_x = gnt_x & req_x & (byteen_x==0), combinationally.
REQ-015 NONE: req_0 only -> M0; req_1 only -> M1; both -> master not last-served; none -> NONE.
REQ-016 Mx, req_x low: go to other master if it requests, else NONE.
REQ-017 Mx, req_x high, other not requesting: stay Mx.
REQ-018 Mx, req_x high, other requesting: stay while hold_cnt < MAX_HOLD, else switch to other.
REQ-019 SHALL increment hold_cnt (4 bits, saturating at 15) per transfer; SHALL clear it to 0 on any owner change.
REQ-020 SHALL set last-served to x whenever owner becomes Mx.
REQ-021 Grant latency: request raised in cycle n with bus idle -> gnt in cycle n+1; first transfer in n+1.
REQ-022 Ownership hand-over SHALL take exactly one edge; no idle cycle between owners when both request.
REQ-023 A master never receives gnt while the other master's gnt is high (mutual exclusion, every cycle).
REQ-024 req_x dropped while granted: no transfer that cycle, bus_byteen=0, ownership released at next edge per REQ-016.

Reset
REQ-025 While reset low: owner=NONE, last-served=M1 (so M0 wins first tie), hold_cnt=0, gnt_0=gnt_1=0.
REQ-026 Outputs SHALL reach reset values asynchronously on reset falling, independent of clk.
REQ-027 Reset asserted mid-transfer: transfer aborted, bus_byteen=0 immediately; masters SHALL re-request after release.
REQ-028 First edge after reset release SHALL evaluate REQ-015 normally.

Verification
REQ-029 Single read: req_0=1, addr_0=0x100, byteen_0=0, bus_rdata=0xDEADBEEF -> gnt_0=1 next cycle, rvalid_0=1, rdata=0xDEADBEEF, bus_addr=0x100.
REQ-030 Tie after reset: req_0=req_1=1 same cycle -> gnt_0 first; with MAX_HOLD=4 exactly 4 M0 transfers, then gnt_1 on next cycle, no idle gap.
REQ-031 Write pass-through: M1 owner, addr_1=0x7F04, wdata_1=0x12345678, byteen_1=4'b1111 -> bus mirrors, rvalid_1=0.
REQ-032 Release: M0 owner drops req_0 while req_1=1 -> bus_byteen=0 that cycle, gnt_1=1 next cycle, hold_cnt restarts at 0.
REQ-033 Async reset mid-burst: reset low between edges during M1 transfer -> gnt_1=0 and bus_byteen=0 before next edge; after release, req_0=req_1=1 -> M0 granted.
REQ-034 Random 10k-cycle stress: assert gnt_0&gnt_1 never true, and every request granted within 2*MAX_HOLD+1 cycles.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-master, single-slave arbiter in front of a memory bridge.
// Ownership is a registered state (NONE / M0 / M1) with a per-owner hold
// counter bounding how long one master may keep the bus while the other waits.
// Ties from NONE go to the master that was not served last.
//
// Handshake: a master raises req_x with a stable addr/wdata/byteen payload and
// holds it until granted. A transfer happens in every cycle where gnt_x and
// req_x are both high (one per cycle). Dropping req_x while granted means no
// transfer that cycle (bus outputs go to zero), and ownership is released at
// the next rising edge. Read data (bus_rdata) is returned in the same cycle and
// flagged by rvalid_x.
module dm_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_0,
    input  logic [31:0] addr_0,
    input  logic [31:0] wdata_0,
    input  logic [3:0]  byteen_0,
    input  logic        req_1,
    input  logic [31:0] addr_1,
    input  logic [31:0] wdata_1,
    input  logic [3:0]  byteen_1,
    output logic        gnt_0,
    output logic        gnt_1,
    output logic        rvalid_0,
    output logic        rvalid_1,
    output logic [31:0] rdata,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byteen,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  dbg_owner,
    output logic [3:0]  dbg_hold_cnt,
    output logic        dbg_last_served
);

    // Owner encoding is one-hot per master so each grant is a bare flop bit.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } owner_e;

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

    owner_e     owner_q;
    owner_e     owner_d;
    logic       last_q;     // 0: M0 served last, 1: M1 served last
    logic       last_d;
    logic [3:0] hold_q;
    logic [3:0] hold_d;
    logic [3:0] hold_after; // hold count including this cycle's transfer
    logic       xfer;

    assign gnt_0           = owner_q[0];
    assign gnt_1           = owner_q[1];
    assign dbg_owner       = owner_q;
    assign dbg_hold_cnt    = hold_q;
    assign dbg_last_served = last_q;

    // State register: owner, last-served flag and hold counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= OWN_NONE;
            last_q  <= 1'b1;
            hold_q  <= 4'd0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state: arbitration decision, hold counting and last-served update.
    // The hold limit is compared against the count that includes the current
    // transfer, so an owner gets exactly MAX_HOLD transfers while contended.
    always_comb begin
        owner_d    = owner_q;
        xfer       = (gnt_0 & req_0) | (gnt_1 & req_1);
        hold_after = hold_q;
        if (xfer && hold_q != 4'hF) begin
            hold_after = hold_q + 4'd1;
        end
        case (owner_q)
            OWN_NONE: begin
                if (req_0 && req_1) begin
                    owner_d = last_q ? OWN_M0 : OWN_M1;
                end else if (req_0) begin
                    owner_d = OWN_M0;
                end else if (req_1) begin
                    owner_d = OWN_M1;
                end else begin
                    owner_d = OWN_NONE;
                end
            end
            OWN_M0: begin
                if (!req_0) begin
                    owner_d = req_1 ? OWN_M1 : OWN_NONE;
                end else if (req_1 && hold_after >= HOLD_LIMIT) begin
                    owner_d = OWN_M1;
                end else begin
                    owner_d = OWN_M0;
                end
            end
            OWN_M1: begin
                if (!req_1) begin
                    owner_d = req_0 ? OWN_M0 : OWN_NONE;
                end else if (req_0 && hold_after >= HOLD_LIMIT) begin
                    owner_d = OWN_M0;
                end else begin
                    owner_d = OWN_M1;
                end
            end
            default: owner_d = OWN_NONE;
        endcase

        last_d = last_q;
        if (owner_d == OWN_M0 && owner_q != OWN_M0) begin
            last_d = 1'b0;
        end else if (owner_d == OWN_M1 && owner_q != OWN_M1) begin
            last_d = 1'b1;
        end

        hold_d = (owner_d != owner_q) ? 4'd0 : hold_after;
    end

    // Outputs: bus mux from the active owner, read-valid flags, shared rdata.
    always_comb begin
        bus_addr   = 32'h0;
        bus_wdata  = 32'h0;
        bus_byteen = 4'h0;
        if (gnt_0 && req_0) begin
            bus_addr   = addr_0;
            bus_wdata  = wdata_0;
            bus_byteen = byteen_0;
        end else if (gnt_1 && req_1) begin
            bus_addr   = addr_1;
            bus_wdata  = wdata_1;
            bus_byteen = byteen_1;
        end
        rvalid_0 = gnt_0 & req_0 & (byteen_0 == 4'h0);
        rvalid_1 = gnt_1 & req_1 & (byteen_1 == 4'h0);
        rdata    = bus_rdata;
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter plus a randomized fairness/exclusion run.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
module tb_dm_arbiter;

    localparam int unsigned MAX_HOLD = 4;
    localparam int BOUND = 2 * MAX_HOLD + 1;
    localparam int STRESS_CYCLES = 10000;
    localparam logic [1:0] OWN_NONE = 2'b00;

    logic        clk;
    logic        reset;
    logic        req_0;
    logic [31:0] addr_0;
    logic [31:0] wdata_0;
    logic [3:0]  byteen_0;
    logic        req_1;
    logic [31:0] addr_1;
    logic [31:0] wdata_1;
    logic [3:0]  byteen_1;
    logic        gnt_0;
    logic        gnt_1;
    logic        rvalid_0;
    logic        rvalid_1;
    logic [31:0] rdata;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_rdata;
    logic [1:0]  dbg_owner;
    logic [3:0]  dbg_hold_cnt;
    logic        dbg_last_served;

    int checks;
    int errors;

    // Stress-run model state
    logic        nreq[2];
    int          rem[2];
    int          wt[2];
    logic [31:0] pa[2];
    logic [3:0]  pb[2];
    logic        gg[2];
    logic        rr[2];
    logic [3:0]  exp_be;

    dm_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(reset),
        .req_0(req_0), .addr_0(addr_0), .wdata_0(wdata_0), .byteen_0(byteen_0),
        .req_1(req_1), .addr_1(addr_1), .wdata_1(wdata_1), .byteen_1(byteen_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
        .rdata(rdata), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_byteen(bus_byteen), .bus_rdata(bus_rdata),
        .dbg_owner(dbg_owner), .dbg_hold_cnt(dbg_hold_cnt),
        .dbg_last_served(dbg_last_served)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        req_0 = 1'b0; req_1 = 1'b0;
        addr_0 = 32'h0; addr_1 = 32'h0;
        wdata_0 = 32'h0; wdata_1 = 32'h0;
        byteen_0 = 4'h0; byteen_1 = 4'h0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset();
        req_0 = 1'b1; req_1 = 1'b1; byteen_0 = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (gnt_0 !== 1'b0) begin errors++; $display("FAIL rst_gnt0 got %b exp 0", gnt_0); end
        checks++; if (gnt_1 !== 1'b0) begin errors++; $display("FAIL rst_gnt1 got %b exp 0", gnt_1); end
        checks++; if (dbg_owner !== OWN_NONE) begin errors++; $display("FAIL rst_owner got %b exp 00", dbg_owner); end
        checks++; if (dbg_hold_cnt !== 4'd0) begin errors++; $display("FAIL rst_hold got %0d exp 0", dbg_hold_cnt); end
        checks++; if (dbg_last_served !== 1'b1) begin errors++; $display("FAIL rst_last got %b exp 1", dbg_last_served); end
        checks++; if (bus_byteen !== 4'h0) begin errors++; $display("FAIL rst_byteen got %h exp 0", bus_byteen); end
        req_0 = 1'b0; req_1 = 1'b0; byteen_0 = 4'h0;
        next_cycle();
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++; if (gnt_0 !== 1'b0 || gnt_1 !== 1'b0) begin errors++; $display("FAIL rst_idle_gnt got %b%b exp 00", gnt_1, gnt_0); end
        next_cycle();
    endtask

    task automatic test_single_read();
        req_0 = 1'b1; addr_0 = 32'h100; byteen_0 = 4'h0; bus_rdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (gnt_0 !== 1'b0) begin errors++; $display("FAIL rd_latency_gnt0 got %b exp 0", gnt_0); end
        next_cycle();
        @(negedge clk);
        checks++; if (gnt_0 !== 1'b1) begin errors++; $display("FAIL rd_gnt0 got %b exp 1", gnt_0); end
        checks++; if (gnt_1 !== 1'b0) begin errors++; $display("FAIL rd_gnt1 got %b exp 0", gnt_1); end
        checks++; if (rvalid_0 !== 1'b1) begin errors++; $display("FAIL rd_rvalid0 got %b exp 1", rvalid_0); end
        checks++; if (rvalid_1 !== 1'b0) begin errors++; $display("FAIL rd_rvalid1 got %b exp 0", rvalid_1); end
        checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata got %h exp deadbeef", rdata); end
        checks++; if (bus_addr !== 32'h100) begin errors++; $display("FAIL rd_bus_addr got %h exp 100", bus_addr); end
        next_cycle();
        req_0 = 1'b0;
        @(negedge clk);
        checks++; if (gnt_0 !== 1'b1) begin errors++; $display("FAIL rd_drop_gnt0 got %b exp 1", gnt_0); end
        checks++; if (rvalid_0 !== 1'b0) begin errors++; $display("FAIL rd_drop_rvalid0 got %b exp 0", rvalid_0); end
        checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL rd_drop_addr got %h exp 0", bus_addr); end
        next_cycle();
        @(negedge clk);
        checks++; if (dbg_owner !== OWN_NONE) begin errors++; $display("FAIL rd_release_owner got %b exp 00", dbg_owner); end
        idle_bus();
    endtask

    task automatic test_tie_hold();
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        req_0 = 1'b1; addr_0 = 32'hA0; byteen_0 = 4'h1;
        req_1 = 1'b1; addr_1 = 32'hB0; byteen_1 = 4'h2;
        @(negedge clk);
        checks++; if (gnt_0 !== 1'b0 || gnt_1 !== 1'b0) begin errors++; $display("FAIL tie_idle got %b%b exp 00", gnt_1, gnt_0); end
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            @(negedge clk);
            checks++; if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0) begin errors++; $display("FAIL tie_m0_%0d got gnt %b%b exp 01", i, gnt_1, gnt_0); end
            checks++; if (bus_addr !== 32'hA0) begin errors++; $display("FAIL tie_m0_addr_%0d got %h exp a0", i, bus_addr); end
        end
        next_cycle();
        @(negedge clk);
        checks++; if (gnt_1 !== 1'b1 || gnt_0 !== 1'b0) begin errors++; $display("FAIL tie_switch got gnt %b%b exp 10", gnt_1, gnt_0); end
        checks++; if (bus_byteen !== 4'h2) begin errors++; $display("FAIL tie_switch_be got %h exp 2", bus_byteen); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            checks++; if (gnt_1 !== 1'b1 || gnt_0 !== 1'b0) begin errors++; $display("FAIL tie_m1_%0d got gnt %b%b exp 10", i, gnt_1, gnt_0); end
        end
        next_cycle();
        @(negedge clk);
        checks++; if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0) begin errors++; $display("FAIL tie_back_m0 got gnt %b%b exp 01", gnt_1, gnt_0); end
        req_0 = 1'b0; req_1 = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++; if (dbg_owner !== OWN_NONE) begin errors++; $display("FAIL tie_release got %b exp 00", dbg_owner); end
        idle_bus();
    endtask

    task automatic test_write();
        req_1 = 1'b1; addr_1 = 32'h7F04; wdata_1 = 32'h12345678; byteen_1 = 4'hF;
        bus_rdata = 32'hCAFE0001;
        next_cycle();
        @(negedge clk);
        checks++; if (gnt_1 !== 1'b1) begin errors++; $display("FAIL wr_gnt1 got %b exp 1", gnt_1); end
        checks++; if (bus_addr !== 32'h7F04) begin errors++; $display("FAIL wr_addr got %h exp 7f04", bus_addr); end
        checks++; if (bus_wdata !== 32'h12345678) begin errors++; $display("FAIL wr_wdata got %h exp 12345678", bus_wdata); end
        checks++; if (bus_byteen !== 4'hF) begin errors++; $display("FAIL wr_byteen got %h exp f", bus_byteen); end
        checks++; if (rvalid_1 !== 1'b0) begin errors++; $display("FAIL wr_rvalid1 got %b exp 0", rvalid_1); end
        checks++; if (rdata !== 32'hCAFE0001) begin errors++; $display("FAIL wr_rdata got %h exp cafe0001", rdata); end
        idle_bus();
    endtask

    task automatic test_release();
        req_0 = 1'b1; addr_0 = 32'h200; wdata_0 = 32'h55; byteen_0 = 4'h3;
        next_cycle();
        req_1 = 1'b1; addr_1 = 32'h300; byteen_1 = 4'hF;
        @(negedge clk);
        checks++; if (bus_byteen !== 4'h3) begin errors++; $display("FAIL rel_m0_be got %h exp 3", bus_byteen); end
        next_cycle();
        req_0 = 1'b0;
        @(negedge clk);
        checks++; if (bus_byteen !== 4'h0) begin errors++; $display("FAIL rel_drop_be got %h exp 0", bus_byteen); end
        checks++; if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0) begin errors++; $display("FAIL rel_drop_gnt got %b%b exp 01", gnt_1, gnt_0); end
        next_cycle();
        @(negedge clk);
        checks++; if (gnt_1 !== 1'b1 || gnt_0 !== 1'b0) begin errors++; $display("FAIL rel_handover got %b%b exp 10", gnt_1, gnt_0); end
        checks++; if (dbg_hold_cnt !== 4'd0) begin errors++; $display("FAIL rel_hold0 got %0d exp 0", dbg_hold_cnt); end
        checks++; if (bus_addr !== 32'h300) begin errors++; $display("FAIL rel_m1_addr got %h exp 300", bus_addr); end
        next_cycle();
        @(negedge clk);
        checks++; if (dbg_hold_cnt !== 4'd1) begin errors++; $display("FAIL rel_hold1 got %0d exp 1", dbg_hold_cnt); end
        idle_bus();
    endtask

    task automatic test_async_reset();
        req_1 = 1'b1; addr_1 = 32'h400; byteen_1 = 4'hF;
        next_cycle();
        @(negedge clk);
        checks++; if (bus_byteen !== 4'hF) begin errors++; $display("FAIL ar_pre_be got %h exp f", bus_byteen); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (gnt_1 !== 1'b0) begin errors++; $display("FAIL ar_gnt1 got %b exp 0", gnt_1); end
        checks++; if (bus_byteen !== 4'h0) begin errors++; $display("FAIL ar_be got %h exp 0", bus_byteen); end
        checks++; if (dbg_owner !== OWN_NONE) begin errors++; $display("FAIL ar_owner got %b exp 00", dbg_owner); end
        req_0 = 1'b1; addr_0 = 32'h500; byteen_0 = 4'h0;
        next_cycle();
        @(negedge clk);
        checks++; if (gnt_0 !== 1'b0 || gnt_1 !== 1'b0) begin errors++; $display("FAIL ar_held got %b%b exp 00", gnt_1, gnt_0); end
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (gnt_0 !== 1'b0 || gnt_1 !== 1'b0) begin errors++; $display("FAIL ar_release got %b%b exp 00", gnt_1, gnt_0); end
        next_cycle();
        @(negedge clk);
        checks++; if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0) begin errors++; $display("FAIL ar_tie_m0 got %b%b exp 01", gnt_1, gnt_0); end
        idle_bus();
    endtask

    task automatic test_stress();
        for (int m = 0; m < 2; m++) begin
            nreq[m] = 1'b0; rem[m] = 0; wt[m] = 0; pa[m] = 32'h0; pb[m] = 4'h0;
        end
        for (int cyc = 0; cyc < STRESS_CYCLES; cyc++) begin
            req_0 = nreq[0]; addr_0 = pa[0]; byteen_0 = pb[0]; wdata_0 = ~pa[0];
            req_1 = nreq[1]; addr_1 = pa[1]; byteen_1 = pb[1]; wdata_1 = ~pa[1];
            @(negedge clk);
            gg[0] = gnt_0; gg[1] = gnt_1; rr[0] = req_0; rr[1] = req_1;
            checks++;
            if (gg[0] && gg[1]) begin
                errors++; $display("FAIL stress_mutex cycle %0d got gnt 11 exp not both", cyc);
            end
            exp_be = (gg[0] && rr[0]) ? pb[0] : ((gg[1] && rr[1]) ? pb[1] : 4'h0);
            checks++;
            if (bus_byteen !== exp_be) begin
                errors++; $display("FAIL stress_byteen cycle %0d got %h exp %h", cyc, bus_byteen, exp_be);
            end
            for (int m = 0; m < 2; m++) begin
                if (rr[m]) begin
                    if (gg[m]) begin
                        checks++;
                        if (wt[m] > BOUND) begin
                            errors++; $display("FAIL stress_latency m%0d cycle %0d got %0d exp <= %0d", m, cyc, wt[m], BOUND);
                        end
                        wt[m] = 0;
                        rem[m] = rem[m] - 1;
                        if (rem[m] == 0) nreq[m] = 1'b0;
                    end else begin
                        wt[m] = wt[m] + 1;
                        if (wt[m] > 4 * BOUND) begin
                            checks++; errors++;
                            $display("FAIL stress_starve m%0d cycle %0d got %0d waiting exp <= %0d", m, cyc, wt[m], BOUND);
                            nreq[m] = 1'b0; wt[m] = 0;
                        end
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    nreq[m] = 1'b1;
                    rem[m] = int'($urandom_range(1, 6));
                    pa[m] = $urandom;
                    pb[m] = 4'($urandom_range(0, 15));
                    wt[m] = 0;
                end
            end
            next_cycle();
        end
        idle_bus();
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0;
        req_0 = 1'b0; addr_0 = 32'h0; wdata_0 = 32'h0; byteen_0 = 4'h0;
        req_1 = 1'b0; addr_1 = 32'h0; wdata_1 = 32'h0; byteen_1 = 4'h0;
        bus_rdata = 32'h0;
        exp_be = 4'h0;
        test_reset();
        test_single_read();
        test_tie_hold();
        test_write();
        test_release();
        test_async_reset();
        test_stress();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
